// File: rtl/cmp_pkg.sv
// Shared types and constants for the serial magnitude comparator.
package cmp_pkg;

   localparam int unsigned DIGIT_W = 2;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   typedef enum logic [2:0] {
      GT = 3'b100,
      EQ = 3'b010,
      LT = 3'b001
   } res_t;

endpackage

// File: rtl/cmp2_slice.sv
// Combinational 2-bit unsigned compare with one-hot gt/eq/lt outputs.
module cmp2_slice
   import cmp_pkg::*;
(
   input  logic [DIGIT_W-1:0] i_a,
   input  logic [DIGIT_W-1:0] i_b,
   output logic               o_gt_c,
   output logic               o_eq_c,
   output logic               o_lt_c
);

   assign o_gt_c = (i_a > i_b);
   assign o_eq_c = (i_a == i_b);
   assign o_lt_c = (i_a < i_b);

endmodule

// File: rtl/serial_magnitude_cmp_ctrl.sv
// Serial WIDTH-bit magnitude comparator, one 2-bit digit per cycle, MSB digit first.
// Define CMP_EARLY_EXIT_EN to terminate on the first unequal digit instead of scanning all digits.
module serial_magnitude_cmp_ctrl
   import cmp_pkg::*;
#(
   parameter int unsigned WIDTH = 8
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic             A_great_B,
   output logic             A_equal_B,
   output logic             A_less_B
);

   localparam int unsigned ND = WIDTH / DIGIT_W;
   localparam int unsigned KW = (ND > 1) ? $clog2(ND) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(ND - 1);

   state_t           r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [KW-1:0]    r_k;
   logic [2:0]       r_res;

   logic       w_gt;
   logic       w_eq;
   logic       w_lt;
   logic [2:0] w_res;
   logic       w_term;
   logic [2:0] w_final;
   logic       w_accept;

   cmp2_slice u_slice (
      .i_a    (r_a[WIDTH-1 -: DIGIT_W]),
      .i_b    (r_b[WIDTH-1 -: DIGIT_W]),
      .o_gt_c (w_gt),
      .o_eq_c (w_eq),
      .o_lt_c (w_lt)
   );

   assign w_res    = {w_gt, w_eq, w_lt};
   assign w_accept = (r_state == IDLE) && start;

`ifdef CMP_EARLY_EXIT_EN
   assign w_term  = !w_eq || (r_k == K_LAST);
   assign w_final = w_res;
`else
   logic       r_found;
   logic [2:0] r_verdict;

   // Hold the first unequal digit's verdict; later digits cannot override it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_found   <= 1'b0;
         r_verdict <= 3'b000;
      end else if (w_accept) begin
         r_found   <= 1'b0;
         r_verdict <= 3'b000;
      end else if ((r_state == RUN) && !w_eq && !r_found) begin
         r_found   <= 1'b1;
         r_verdict <= w_res;
      end
   end

   assign w_term  = (r_k == K_LAST);
   assign w_final = r_found ? r_verdict : w_res;
`endif

   // Control FSM, operand shift registers, digit counter and result registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_k     <= '0;
         r_res   <= 3'b000;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_state <= RUN;
                  r_a     <= A;
                  r_b     <= B;
                  r_k     <= '0;
                  r_res   <= 3'b000;
                  busy    <= 1'b1;
               end
            end
            RUN: begin
               if (w_term) begin
                  r_state <= IDLE;
                  r_res   <= w_final;
                  busy    <= 1'b0;
                  done    <= 1'b1;
               end else begin
                  r_a <= r_a << DIGIT_W;
                  r_b <= r_b << DIGIT_W;
                  r_k <= r_k + KW'(1);
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign A_great_B = r_res[2];
   assign A_equal_B = r_res[1];
   assign A_less_B  = r_res[0];

endmodule

// File: tb/tb_serial_magnitude_cmp_ctrl.sv
// Directed bench for serial_magnitude_cmp_ctrl (WIDTH=8); follows CMP_EARLY_EXIT_EN for latency.
module tb_serial_magnitude_cmp_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] A;
   logic [7:0] B;
   logic       busy;
   logic       done;
   logic       A_great_B;
   logic       A_equal_B;
   logic       A_less_B;

   int errors = 0;
   int checks = 0;

   serial_magnitude_cmp_ctrl #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .A         (A),
      .B         (B),
      .busy      (busy),
      .done      (done),
      .A_great_B (A_great_B),
      .A_equal_B (A_equal_B),
      .A_less_B  (A_less_B)
   );

   always #5 clk = ~clk;

   typedef struct {
      string      nm;
      logic [7:0] a;
      logic [7:0] b;
      logic [2:0] exp;
      int         idx;
   } vec_t;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic int lat_of(input int idx);
`ifdef CMP_EARLY_EXIT_EN
      return idx + 1;
`else
      return (idx >= 0) ? 4 : 4;
`endif
   endfunction

   function automatic logic [2:0] flags();
      return {A_great_B, A_equal_B, A_less_B};
   endfunction

   task automatic wait_done(output int cnt);
      cnt = 0;
      do begin
         @(posedge clk); #1;
         cnt++;
      end while (!done && cnt < 20);
   endtask

   task automatic do_cmp(input string nm, input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] exp, input int lat, input int hold);
      int cnt;
      @(negedge clk);
      start = 1'b1; A = a; B = b;
      @(posedge clk); #1;
      start = 1'b0; A = ~a; B = ~b;
      chk({nm, " busy_on_accept"}, 32'(busy), 32'd1);
      chk({nm, " flags_cleared"}, 32'(flags()), 32'd0);
      wait_done(cnt);
      chk({nm, " latency"}, 32'(cnt), 32'(lat));
      chk({nm, " result"}, 32'(flags()), 32'(exp));
      chk({nm, " busy_at_done"}, 32'(busy), 32'd0);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         chk({nm, " done_pulse_end"}, 32'(done), 32'd0);
         chk({nm, " flags_hold"}, 32'(flags()), 32'(exp));
      end
   endtask

   initial begin
      vec_t vecs[10];
      int   cnt;
      bit   saw_done;

      vecs[0] = '{"eq_a5",   8'hA5, 8'hA5, 3'b010, 3};
      vecs[1] = '{"gt_80",   8'h80, 8'h7F, 3'b100, 0};
      vecs[2] = '{"lt_34",   8'h34, 8'h37, 3'b001, 3};
      vecs[3] = '{"eq_00",   8'h00, 8'h00, 3'b010, 3};
      vecs[4] = '{"gt_ff",   8'hFF, 8'h00, 3'b100, 0};
      vecs[5] = '{"lt_01",   8'h01, 8'h02, 3'b001, 3};
      vecs[6] = '{"lt_c4",   8'hC4, 8'hC8, 3'b001, 2};
      vecs[7] = '{"gt_0f",   8'h0F, 8'h0B, 3'b100, 2};
      vecs[8] = '{"gt_5a",   8'h5A, 8'h4A, 3'b100, 1};
      vecs[9] = '{"lt_00ff", 8'h00, 8'hFF, 3'b001, 0};

      rst = 1'b1; start = 1'b0; A = 8'h00; B = 8'h00;
      #12;
      chk("reset busy", 32'(busy), 32'd0);
      chk("reset done", 32'(done), 32'd0);
      chk("reset flags", 32'(flags()), 32'd0);
      @(negedge clk); rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         chk("idle busy", 32'(busy), 32'd0);
         chk("idle done_flags", 32'({done, flags()}), 32'd0);
      end

      do_cmp("hold_a5", 8'hA5, 8'hA5, 3'b010, 4, 5);

      foreach (vecs[i])
         do_cmp(vecs[i].nm, vecs[i].a, vecs[i].b, vecs[i].exp, lat_of(vecs[i].idx), 1);

      // Starts while busy are ignored; start in the done cycle is accepted.
      @(negedge clk);
      start = 1'b1; A = 8'h01; B = 8'h02;
      @(posedge clk); #1;
      A = 8'hFF; B = 8'h00;
      @(posedge clk); #1;
      chk("busy_ign busy", 32'(busy), 32'd1);
      @(posedge clk); #1;
      start = 1'b0;
      cnt = 2;
      do begin
         @(posedge clk); #1;
         cnt++;
      end while (!done && cnt < 20);
      chk("busy_ign latency", 32'(cnt), 32'd4);
      chk("busy_ign result", 32'(flags()), 32'(3'b001));
      start = 1'b1; A = 8'hFF; B = 8'h00;
      @(posedge clk); #1;
      start = 1'b0;
      chk("b2b done_drop", 32'(done), 32'd0);
      chk("b2b flags_clr", 32'(flags()), 32'd0);
      chk("b2b busy", 32'(busy), 32'd1);
      wait_done(cnt);
      chk("b2b latency", 32'(cnt), 32'(lat_of(0)));
      chk("b2b result", 32'(flags()), 32'(3'b100));

      // Reset mid-run discards the comparison.
      @(negedge clk);
      start = 1'b1; A = 8'h12; B = 8'h13;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      chk("midrst busy", 32'(busy), 32'd0);
      chk("midrst done_flags", 32'({done, flags()}), 32'd0);
      @(negedge clk); rst = 1'b0;
      saw_done = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         if (done || busy) saw_done = 1'b1;
      end
      chk("midrst no_done", 32'(saw_done), 32'd0);
      do_cmp("after_rst", 8'h12, 8'h13, 3'b001, 4, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
